// File: rtl/dcache_write_buffer.sv
// Victim-line write buffer between dcache and memory: FIFO, drain FSM, read lookup.
// Optional WB_MERGE_EN: writes to an already-buffered line overwrite it in place.
module dcache_write_buffer #(
    parameter int DEPTH            = 4,
    parameter int ADDR_SIZE        = 32,
    parameter int PACKED_DATA_SIZE = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        dcache_write_buffer_en,
    input  logic [ADDR_SIZE-1:0]        dcache_write_buffer_physical_addr,
    input  logic [PACKED_DATA_SIZE-1:0] dcache_write_buffer_data,
    output logic                        buffer_ready_for_dcache_write,
    output logic                        buffer_receive_dcache_write_ok,
    input  logic                        lookup_en,
    input  logic [ADDR_SIZE-1:0]        lookup_physical_addr,
    output logic                        buffer_hit_success,
    output logic [31:0]                 buffer_hit_data,
    output logic                        wb_write_mem_en,
    output logic [ADDR_SIZE-1:0]        wb_write_mem_addr,
    output logic [PACKED_DATA_SIZE-1:0] wb_write_mem_data,
    input  logic                        mem_ready_for_wb_write,
    input  logic                        mem_write_done,
    output logic                        wb_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = ADDR_SIZE - 5;
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    localparam logic [1:0] WB_IDLE = 2'd0;
    localparam logic [1:0] WB_REQ  = 2'd1;
    localparam logic [1:0] WB_WAIT = 2'd2;

    logic [DEPTH-1:0]            valid_q;
    logic [LW-1:0]               addr_q [DEPTH];
    logic [PACKED_DATA_SIZE-1:0] data_q [DEPTH];
    logic [PW-1:0]               head_q;
    logic [PW-1:0]               tail_q;
    logic [PW:0]                 count_q;
    logic [1:0]                  state_q;
    logic [1:0]                  state_d;

    logic [LW-1:0] wr_line;
    logic [LW-1:0] lk_line;
    logic          push;
    logic          pop;
    logic          alloc;
    logic          merge_hit;
    logic [PW-1:0] merge_idx;
    logic          hit;
    logic [PW-1:0] hit_idx;
    logic [PW-1:0] lk_idx;
    logic          unused_bits;

    assign wr_line = dcache_write_buffer_physical_addr[ADDR_SIZE-1:5];
    assign lk_line = lookup_physical_addr[ADDR_SIZE-1:5];
    assign unused_bits = ^{dcache_write_buffer_physical_addr[4:0],
                           lookup_physical_addr[1:0]};

    assign buffer_ready_for_dcache_write = (count_q != FULL);
    assign push = dcache_write_buffer_en && buffer_ready_for_dcache_write;
    assign buffer_receive_dcache_write_ok = push;
    assign pop = (state_q == WB_WAIT) && mem_write_done;
    assign alloc = push && !merge_hit;
    assign wb_empty = (count_q == '0);

`ifdef WB_MERGE_EN
    logic [PW-1:0] m_idx;

    // The head is excluded once its drain has started: memory may already hold the old copy.
    always_comb begin
        merge_hit = 1'b0;
        merge_idx = '0;
        m_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            m_idx = head_q + PW'(i);
            if (valid_q[m_idx] && addr_q[m_idx] == wr_line &&
                !(i == 0 && state_q != WB_IDLE)) begin
                merge_hit = 1'b1;
                merge_idx = m_idx;
            end
        end
    end
`else
    assign merge_hit = 1'b0;
    assign merge_idx = '0;
`endif

    // Walk oldest to newest so the youngest matching entry wins.
    always_comb begin
        hit = 1'b0;
        hit_idx = '0;
        lk_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = head_q + PW'(i);
            if (valid_q[lk_idx] && addr_q[lk_idx] == lk_line) begin
                hit = 1'b1;
                hit_idx = lk_idx;
            end
        end
    end

    assign buffer_hit_success = lookup_en && hit;
    assign buffer_hit_data = buffer_hit_success ?
        data_q[hit_idx][{lookup_physical_addr[4:2], 5'b0} +: 32] : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WB_IDLE: if (count_q != '0) state_d = WB_REQ;
            WB_REQ:  if (mem_ready_for_wb_write) state_d = WB_WAIT;
            WB_WAIT: if (mem_write_done) state_d = WB_IDLE;
            default: state_d = WB_IDLE;
        endcase
    end

    assign wb_write_mem_en = (state_q == WB_REQ);
    assign wb_write_mem_addr = wb_write_mem_en ? {addr_q[head_q], 5'b0} : '0;
    assign wb_write_mem_data = wb_write_mem_en ? data_q[head_q] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= WB_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (alloc) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= wr_line;
                data_q[tail_q]  <= dcache_write_buffer_data;
                tail_q          <= tail_q + PW'(1);
            end
            if (push && merge_hit) begin
                data_q[merge_idx] <= dcache_write_buffer_data;
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PW'(1);
            end
            if (alloc && !pop) begin
                count_q <= count_q + (PW + 1)'(1);
            end else if (pop && !alloc) begin
                count_q <= count_q - (PW + 1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_dcache_write_buffer.sv
// Bench for dcache_write_buffer: directed scenarios plus randomized traffic
// checked against a queue-based model of the buffer.
module tb_dcache_write_buffer;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [31:0]  paddr = '0;
    logic [255:0] pdata = '0;
    logic         ready;
    logic         ok;
    logic         lookup_en = 1'b0;
    logic [31:0]  laddr = '0;
    logic         hit;
    logic [31:0]  hit_data;
    logic         mem_en;
    logic [31:0]  mem_addr;
    logic [255:0] mem_data;
    logic         mem_ready = 1'b0;
    logic         mem_done = 1'b0;
    logic         empty;

    int checks = 0;
    int errors = 0;

    dcache_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .dcache_write_buffer_en(en),
        .dcache_write_buffer_physical_addr(paddr),
        .dcache_write_buffer_data(pdata),
        .buffer_ready_for_dcache_write(ready),
        .buffer_receive_dcache_write_ok(ok),
        .lookup_en(lookup_en),
        .lookup_physical_addr(laddr),
        .buffer_hit_success(hit),
        .buffer_hit_data(hit_data),
        .wb_write_mem_en(mem_en),
        .wb_write_mem_addr(mem_addr),
        .wb_write_mem_data(mem_data),
        .mem_ready_for_wb_write(mem_ready),
        .mem_write_done(mem_done),
        .wb_empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [26:0]  line;
        logic [255:0] data;
    } ent_t;

    // Model: buffered lines oldest first, plus the drain phase of the head
    // (0 waiting to be offered, 1 offered to memory, 2 awaiting completion).
    ent_t q[$];
    int   dph = 0;
    int   drained = 0;
    logic [255:0] first_data;

    function automatic logic [255:0] rand_line();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    function automatic bit mdl_hit(input logic [31:0] a, output logic [31:0] w);
        bit h = 0;
        w = '0;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].line == a[31:5]) begin
                h = 1;
                w = q[i].data[{a[4:2], 5'b0} +: 32];
            end
        end
        return h;
    endfunction

    task automatic tick();
        bit   acc;
        int   n0;
        int   m;
        ent_t e;
        n0 = q.size();
        acc = en && (n0 != DEPTH);
        if (acc) begin
            m = -1;
`ifdef WB_MERGE_EN
            for (int i = n0 - 1; i >= 0; i--)
                if (m < 0 && q[i].line == paddr[31:5] && !(i == 0 && dph != 0)) m = i;
`endif
            if (m >= 0) begin
                q[m].data = pdata;
            end else begin
                e.line = paddr[31:5];
                e.data = pdata;
                q.push_back(e);
            end
        end
        if (dph == 0 && n0 != 0) dph = 1;
        else if (dph == 1 && mem_ready) dph = 2;
        else if (dph == 2 && mem_done) begin
            dph = 0;
            void'(q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        lookup_en = 1'b1;
        laddr = 32'h0000_1004;
        #2;
        checks++;
        if ({ready, empty, mem_en, hit} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_flags: got %b want 1100", {ready, empty, mem_en, hit});
        end
        checks++;
        if (mem_addr !== '0 || mem_data !== '0 || hit_data !== '0) begin
            errors++;
            $display("FAIL reset_values: got addr %h hitdata %h want 0", mem_addr, hit_data);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        lookup_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [255:0] d;
        for (int w = 0; w < 8; w++) d[32*w +: 32] = w;
        en = 1'b1;
        paddr = 32'h0000_1000;
        pdata = d;
        #2;
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL single_ok: got %b want 1", ok);
        end
        tick();
        en = 1'b0;
        #2;
        checks++;
        if (mem_en !== 1'b0) begin
            errors++;
            $display("FAIL single_en_early: got %b want 0", mem_en);
        end
        tick();
        #2;
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h0000_1000 || mem_data !== d) begin
            errors++;
            $display("FAIL single_req: got en %b addr %h want en 1 addr 00001000", mem_en, mem_addr);
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        lookup_en = 1'b1;
        laddr = 32'h0000_100C;
        #2;
        checks++;
        if (hit !== 1'b1 || hit_data !== 32'd3 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL lookup_wait: got hit %b data %h en %b want 1 3 0", hit, hit_data, mem_en);
        end
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        #2;
        checks++;
        if (hit !== 1'b0 || hit_data !== '0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL lookup_after_done: got hit %b data %h empty %b want 0 0 1", hit, hit_data, empty);
        end
        lookup_en = 1'b0;
    endtask

    task automatic test_drain();
        int cyc = 0;
        drained = 0;
        en = 1'b0;
        lookup_en = 1'b0;
        while (q.size() != 0 && cyc < 300) begin
            mem_ready = ($urandom_range(0, 1) == 1);
            mem_done = ($urandom_range(0, 1) == 1);
            #2;
            checks++;
            if (mem_en !== (dph == 1)) begin
                errors++;
                $display("FAIL drain_en: got %b want %b", mem_en, dph == 1);
            end
            if (dph == 1) begin
                checks++;
                if (mem_addr !== {q[0].line, 5'b0} || mem_data !== q[0].data) begin
                    errors++;
                    $display("FAIL drain_line: got addr %h want %h", mem_addr, {q[0].line, 5'b0});
                end
            end
            if (dph == 2 && mem_done) begin
                if (drained == 0) first_data = q[0].data;
                drained++;
            end
            tick();
            cyc++;
        end
        mem_ready = 1'b0;
        mem_done = 1'b0;
        #2;
        checks++;
        if (empty !== 1'b1 || q.size() != 0) begin
            errors++;
            $display("FAIL drain_empty: got empty %b model %0d want 1 0", empty, q.size());
        end
    endtask

    task automatic test_full();
        logic [255:0] d5;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en = 1'b1;
            paddr = 32'h0000_3000 + 32'(i * 32);
            pdata = rand_line();
            #2;
            checks++;
            if (ok !== 1'b1) begin
                errors++;
                $display("FAIL full_fill_ok%0d: got %b want 1", i, ok);
            end
            tick();
        end
        d5 = rand_line();
        paddr = 32'h0000_3100;
        pdata = d5;
        #2;
        checks++;
        if (ready !== 1'b0 || ok !== 1'b0) begin
            errors++;
            $display("FAIL full_refuse: got ready %b ok %b want 0 0", ready, ok);
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        #2;
        checks++;
        if (ok !== 1'b0) begin
            errors++;
            $display("FAIL full_refuse_wait: got %b want 0", ok);
        end
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        #2;
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL full_accept_after_pop: got %b want 1", ok);
        end
        tick();
        en = 1'b0;
        test_drain();
        checks++;
        if (drained != 4) begin
            errors++;
            $display("FAIL full_drain_count: got %0d want 4", drained);
        end
    endtask

    task automatic test_dup();
        logic [255:0] da;
        logic [255:0] db;
        da = rand_line();
        db = rand_line();
        mem_ready = 1'b0;
        en = 1'b1;
        paddr = 32'h0000_2000;
        pdata = da;
        tick();
        pdata = db;
        #2;
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL dup_ok: got %b want 1", ok);
        end
        tick();
        en = 1'b0;
        lookup_en = 1'b1;
        laddr = 32'h0000_2004;
        #2;
        checks++;
        if (hit !== 1'b1 || hit_data !== db[63:32]) begin
            errors++;
            $display("FAIL dup_lookup: got %b %h want 1 %h", hit, hit_data, db[63:32]);
        end
        test_drain();
        checks++;
`ifdef WB_MERGE_EN
        if (drained != 1 || first_data !== db) begin
            errors++;
            $display("FAIL dup_merge: got %0d lines want 1 with data B", drained);
        end
`else
        if (drained != 2 || first_data !== da) begin
            errors++;
            $display("FAIL dup_order: got %0d lines want 2 with A first", drained);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en = 1'b1;
            paddr = 32'h0000_4000 + 32'(i * 32);
            pdata = rand_line();
            tick();
        end
        en = 1'b0;
        while (dph != 1 && cyc < 10) begin
            tick();
            cyc++;
        end
        #2;
        checks++;
        if (mem_en !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_req: got %b want 1", mem_en);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_en !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_drop: got %b want 0", mem_en);
        end
        q.delete();
        dph = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        checks++;
        if (empty !== 1'b1 || ready !== 1'b1 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after: got empty %b ready %b en %b want 1 1 0", empty, ready, mem_en);
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [6];
        logic [31:0] w;
        bit          h;
        for (int i = 0; i < 6; i++) pool[i] = 32'h0001_0000 + 32'(i * 32);
        for (int c = 0; c < 400; c++) begin
            en = ($urandom_range(0, 1) == 1);
            paddr = pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 31));
            pdata = rand_line();
            lookup_en = ($urandom_range(0, 3) != 0);
            laddr = pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 31));
            mem_ready = ($urandom_range(0, 2) != 0);
            mem_done = ($urandom_range(0, 2) == 0);
            #2;
            h = lookup_en && mdl_hit(laddr, w);
            if (!h) w = '0;
            checks++;
            if ({ready, ok, empty, mem_en} !==
                {q.size() != DEPTH, en && q.size() != DEPTH, q.size() == 0, dph == 1}) begin
                errors++;
                $display("FAIL rand_flags c%0d: got %b want %b", c, {ready, ok, empty, mem_en},
                         {q.size() != DEPTH, en && q.size() != DEPTH, q.size() == 0, dph == 1});
            end
            checks++;
            if (hit !== h || hit_data !== w) begin
                errors++;
                $display("FAIL rand_lookup c%0d: got %b %h want %b %h", c, hit, hit_data, h, w);
            end
            if (dph == 1) begin
                checks++;
                if (mem_addr !== {q[0].line, 5'b0} || mem_data !== q[0].data) begin
                    errors++;
                    $display("FAIL rand_req c%0d: got addr %h want %h", c, mem_addr, {q[0].line, 5'b0});
                end
            end
            tick();
        end
        test_drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_dup();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_write_buffer.md
# dcache_write_buffer

Write buffer between the dcache and memory. It accepts dirty 256-bit victim lines from the dcache, holds them in a FIFO, drains them to memory one line at a time, and answers read lookups so that lines still in flight are never fetched stale. It is the responder for the dcache's write-buffer command and hit-query interface.

## Interface

Parameters:
- `DEPTH`, 4: number of line entries; power of two, ≥2.
- `ADDR_SIZE`, 32: physical address width.
- `PACKED_DATA_SIZE`, 256: line width, eight 32-bit words.

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `dcache_write_buffer_en`  in  1  dcache write command valid.
- `dcache_write_buffer_physical_addr`  in  32  line physical address.
- `dcache_write_buffer_data`  in  256  line data; word i at bits [32i+31:32i].
- `buffer_ready_for_dcache_write`  out  1  entry available.
- `buffer_receive_dcache_write_ok`  out  1  command accepted this cycle.
- `lookup_en`  in  1  dcache miss query valid.
- `lookup_physical_addr`  in  32  query address.
- `buffer_hit_success`  out  1  query hits a buffered line.
- `buffer_hit_data`  out  32  hit word.
- `wb_write_mem_en`  out  1  memory write request.
- `wb_write_mem_addr`  out  32  head line address, low 5 bits zero.
- `wb_write_mem_data`  out  256  head line data.
- `mem_ready_for_wb_write`  in  1  memory can take a request.
- `mem_write_done`  in  1  one-cycle write completion.
- `wb_empty`  out  1  no valid entries.

## Operation

- Storage: `DEPTH` entries of {valid, line address [31:5], data}, plus head pointer, tail pointer, and a count of width log2(DEPTH)+1. The pointers wrap modulo `DEPTH`.
- Enqueue:
  - Accept when `dcache_write_buffer_en && buffer_ready_for_dcache_write`. The line is written at tail, tail increments, and count increments.
  - `buffer_ready_for_dcache_write = (count != DEPTH)`. It uses the registered count and does not look ahead to a same-cycle pop.
  - `buffer_receive_dcache_write_ok = dcache_write_buffer_en && buffer_ready_for_dcache_write`, combinational.
- Lookup:
  - Combinational over registered entries only. An enqueue in the same cycle is not visible.
  - Hit when `lookup_en` is high and any valid entry's address equals `lookup_physical_addr[31:5]`.
  - If several entries match, the newest (closest behind tail) wins.
  - `buffer_hit_data` is word `lookup_physical_addr[4:2]` of the winning entry, and 0 when there is no hit.
  - The head entry stays hittable until its drain completes.
- Drain FSM, states WB_IDLE, WB_REQ, WB_WAIT:
  - WB_IDLE → WB_REQ when count ≠ 0.
  - WB_REQ: `wb_write_mem_en` = 1 with the head address and data. Goes to WB_WAIT on the cycle `mem_ready_for_wb_write` is high.
  - WB_WAIT: `wb_write_mem_en` = 0. On `mem_write_done` the head entry is invalidated, head increments, count decrements, and the FSM returns to WB_IDLE.
  - `mem_write_done` outside WB_WAIT is ignored.
- Simultaneous enqueue and pop in one cycle: count is unchanged and both pointers move.
- `wb_empty = (count == 0)`.

## Timing

- Reset: all entries invalid, pointers and count 0, FSM in WB_IDLE.
- Output values during reset:
  - `buffer_ready_for_dcache_write` = 1.
  - `wb_empty` = 1.
  - `wb_write_mem_en` = 0, and `wb_write_mem_addr` = 0.
  - `wb_write_mem_data` = 0.
  - `buffer_hit_success` = 0, and `buffer_hit_data` = 0.
- Reset during WB_REQ or WB_WAIT drops `wb_write_mem_en` immediately and discards all entries.
- An accepted line is visible to lookup from the next cycle. `wb_write_mem_en` rises two cycles after acceptance into an empty buffer: one cycle to WB_REQ, with en asserted in WB_REQ.
- Minimum drain time is 3 cycles per line (IDLE, REQ, WAIT with done). `wb_empty` rises the cycle after the final `mem_write_done`.
- When full, the buffer refuses commands until the cycle after a pop.

## Configuration

- `WB_MERGE_EN` defined:
  - An accepted command whose line address matches a valid entry other than the head currently in WB_REQ or WB_WAIT overwrites that entry's data in place.
  - Pointers and count are unchanged, and `buffer_receive_dcache_write_ok` still pulses.
  - `buffer_ready_for_dcache_write` remains `count != DEPTH`.
- `WB_MERGE_EN` undefined: every accepted command allocates a new entry, and duplicate lines drain in order.

## Test plan

- Reset, then enqueue line 0x0000_1000 with data words 0..7 → ok pulses the same cycle. `wb_write_mem_en` rises 2 cycles later with addr 0x0000_1000. After `mem_write_done`, `wb_empty` = 1.
- Enqueue 4 lines with memory stalled (`mem_ready_for_wb_write` = 0) → ready = 0 after the 4th. A 5th en gets no ok. The 5th is accepted the cycle after the first `mem_write_done`.
- Lookup 0x0000_100C while line 0x1000 is in WB_WAIT → hit = 1, data = word 3. Lookup the same address the cycle after done → hit = 0, data = 0.
- Enqueue 0x2000 with data A, then 0x2000 with data B. Lookup 0x2004 → data = B word 1. With `WB_MERGE_EN`, count = 1; without it, count = 2 and both lines drain in order.
- Assert `rst_n` = 0 during WB_REQ with 3 entries → `wb_write_mem_en` = 0 immediately, and after release `wb_empty` = 1 and ready = 1.
